// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing imem fetches into a small FIFO for decode; FETCH_PERF_EN adds fetch/flush counters
module fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  pc_src,
    input  logic [ADDR_WIDTH-1:0] pc_target,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [DATA_WIDTH-1:0] id_instr,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic [6:0]            op,
    output logic [2:0]            funct3,
    output logic                  funct7_5
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_flushed
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {BOOT, FETCH, FULL, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc, hold_addr;
    logic [ADDR_WIDTH-1:0] pc_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  push, pop, unused_bits;

    assign unused_bits = ^pc_target[1:0];
    assign push      = state == FETCH && imem_ack && !pc_src;
    assign pop       = id_valid && id_ready && !pc_src;
    assign imem_req  = state == FETCH || state == DRAIN;
    assign imem_addr = state == DRAIN ? hold_addr : pc;
    assign id_valid  = count != '0;
    assign id_instr  = id_valid ? instr_mem[rd_ptr] : NOP;
    assign id_pc     = id_valid ? pc_mem[rd_ptr] : '0;
    assign op        = id_instr[6:0];
    assign funct3    = id_instr[14:12];
    assign funct7_5  = id_instr[30];

    // next state: redirect while waiting drains the stale request, a filling push parks in FULL
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = FETCH;
            FETCH:   state_nxt = (pc_src && !imem_ack) ? DRAIN :
                                 (push && !pop && count == CW'(FIFO_DEPTH - 1)) ? FULL : FETCH;
            FULL:    state_nxt = (pc_src || pop || count < CW'(FIFO_DEPTH)) ? FETCH : FULL;
            DRAIN:   state_nxt = imem_ack ? FETCH : DRAIN;
            default: state_nxt = BOOT;
        endcase
    end

    // PC, held drain address and FIFO pointers; a redirect flushes and overrides push/pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            hold_addr <= RESET_PC;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_src ? {pc_target[ADDR_WIDTH-1:2], 2'b00} : push ? pc + ADDR_WIDTH'(4) : pc;
            hold_addr <= state == DRAIN ? hold_addr : pc;
            wr_ptr    <= pc_src ? '0 : wr_ptr + PW'(push);
            rd_ptr    <= pc_src ? '0 : rd_ptr + PW'(pop);
            count     <= pc_src ? '0 : count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage needs no reset; count alone defines which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    logic dropped;
    assign dropped = imem_ack && ((state == FETCH && pc_src) || state == DRAIN);

    // fetched counts pushes; flushed counts discarded entries plus discarded responses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(push);
            perf_flushed <= perf_flushed + (pc_src ? 32'(count) : 32'd0) + 32'(dropped);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch/redirect stimulus with a queue scoreboard of expected decode PCs
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 0, rst = 0;
    logic        imem_req, imem_ack = 0, pc_src = 0, id_valid, id_ready = 0, funct7_5;
    logic [31:0] imem_addr, imem_rdata = 0, pc_target = 0, id_instr, id_pc;
    logic [6:0]  op;
    logic [2:0]  funct3;

    int          checks = 0, errors = 0, pops = 0;
    int          lat_max = 0, wait_cnt = 0;
    bit          hold_ack = 0, prev_wait = 0;
    logic [31:0] prev_addr = 0, last_addr = 0, next_pc = 0, w;
    logic [31:0] expq[$];

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_src(pc_src), .pc_target(pc_target),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .op(op), .funct3(funct3), .funct7_5(funct7_5)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_5013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic restart(input logic [31:0] a);
        expq.delete();
        next_pc = {a[31:2], 2'b00};
    endtask

    task automatic refill();
        while (expq.size() < 8) begin
            expq.push_back(next_pc);
            next_pc += 32'd4;
        end
    endtask

    // one cycle of stimulus and memory response, driven on the falling edge
    task automatic drive(input bit rdy, input bit redir, input logic [31:0] tgt);
        @(negedge clk);
        if (prev_wait) begin
            chk("req_stable", {31'b0, imem_req}, 32'd1);
            chk("addr_stable", imem_addr, prev_addr);
        end
        id_ready   = rdy;
        pc_src     = redir;
        pc_target  = tgt;
        imem_ack   = 0;
        imem_rdata = $urandom;
        last_addr  = imem_addr;
        if (imem_req && !hold_ack) begin
            if (wait_cnt == 0) begin
                imem_ack   = 1;
                imem_rdata = mem_word(imem_addr);
                wait_cnt   = $urandom_range(0, lat_max);
            end else wait_cnt--;
        end
        prev_wait = imem_req && !imem_ack;
        prev_addr = imem_addr;
        if (redir) restart(tgt);
        refill();
    endtask

    // monitor: every visible decode entry must match the scoreboard head
    initial forever begin
        @(negedge clk);
        #1;
        if (rst && !pc_src) begin
            if (!id_valid) chk("idle_nop", id_instr, NOP);
            else if (expq.size() == 0) chk("queue_empty", id_pc, 32'hxxxx_xxxx);
            else begin
                w = mem_word(expq[0]);
                chk("id_pc", id_pc, expq[0]);
                chk("id_instr", id_instr, w);
                chk("op", {25'b0, op}, {25'b0, w[6:0]});
                chk("funct3", {29'b0, funct3}, {29'b0, w[14:12]});
                chk("funct7_5", {31'b0, funct7_5}, {31'b0, w[30]});
                if (id_ready) begin
                    void'(expq.pop_front());
                    pops++;
                end
            end
        end
    end

    initial begin
        restart(32'h0);
        refill();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_instr", id_instr, NOP);
        chk("rst_pc", id_pc, 32'h0);
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0);
            chk($sformatf("seq_addr%0d", i), last_addr, 32'(i * 4));
        end
        repeat (6) drive(0, 0, 0);
        chk("full_req", {31'b0, imem_req}, 32'd0);
        chk("full_valid", {31'b0, id_valid}, 32'd1);
        chk("full_pc", id_pc, expq[0]);
        repeat (6) drive(1, 0, 0);
        chk("resume_req", {31'b0, imem_req}, 32'd1);
        hold_ack = 1;
        repeat (2) drive(1, 0, 0);
        drive(1, 1, 32'h103);
        repeat (2) drive(1, 0, 0);
        hold_ack = 0;
        wait_cnt = 0;
        drive(1, 0, 0);
        drive(1, 0, 0);
        chk("redir_addr", last_addr, 32'h100);
        repeat (4) drive(1, 0, 0);
        chk("pre_valid", {31'b0, id_valid}, 32'd1);
        drive(1, 1, 32'h200);
        chk("ack_pop_redir", {31'b0, imem_ack}, 32'd1);
        drive(1, 0, 0);
        chk("flush_valid", {31'b0, id_valid}, 32'd0);
        chk("flush_instr", id_instr, NOP);
        chk("flush_addr", last_addr, 32'h200);
        drive(1, 0, 0);
        chk("latency2", {31'b0, id_valid}, 32'd1);
        drive(1, 1, 32'hFFFF_FFF8);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0);
            chk($sformatf("wrap_addr%0d", i), last_addr, 32'hFFFF_FFF8 + 32'(i * 4));
        end
        repeat (4) drive(1, 0, 0);
        hold_ack = 1;
        repeat (2) drive(1, 0, 0);
        rst = 0;
        prev_wait = 0;
        #1;
        chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
        chk("mid_rst_valid", {31'b0, id_valid}, 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        restart(32'h0);
        refill();
        hold_ack = 0;
        wait_cnt = 0;
        @(negedge clk);
        imem_ack = 1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rst = 1;
        imem_rdata = 32'hDEAD_BEEF;
        chk("boot_req", {31'b0, imem_req}, 32'd0);
        drive(1, 0, 0);
        chk("boot_addr", last_addr, 32'h0);
        lat_max = 3;
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, $urandom);
        chk("progress", {31'b0, pops > 400}, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
